// File: rtl/parking_pkg.sv
// Shared constants, count type and the hour-to-university-capacity table.
package parking_pkg;

  localparam int TOTAL_SPACES    = 700;
  localparam int CYCLES_PER_HOUR = 256;
  localparam int START_HOUR      = 8;

  // Occupancy/vacancy counts; pools never exceed 500 cars.
  typedef logic [8:0] count_t;

  // University pool capacity for a given hour of day.
  function automatic count_t uni_capacity(input logic [4:0] hour);
    count_t cap;
    cap = 9'd200;
    if (hour >= 5'd8 && hour <= 5'd12) cap = 9'd500;
    else if (hour == 5'd13)            cap = 9'd450;
    else if (hour == 5'd14)            cap = 9'd400;
    else if (hour == 5'd15)            cap = 9'd350;
    return cap;
  endfunction

endpackage

// File: rtl/parking_clock.sv
// Time-of-day keeper: counts cycles within an hour and advances the hour.
module parking_clock
  import parking_pkg::*;
#(
  parameter int CYCLES_PER_HOUR = parking_pkg::CYCLES_PER_HOUR,
  parameter int START_HOUR      = parking_pkg::START_HOUR
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] hour
);

  localparam int CW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_HOUR - 1);

  logic [CW-1:0] cycle_q, cycle_d;
  logic [4:0]    hour_q, hour_d;

  // Next cycle count and hour, wrapping 23 -> 0.
  always_comb begin
    cycle_d = cycle_q + CW'(1);
    hour_d  = hour_q;
    if (cycle_q == CYC_LAST) begin
      cycle_d = '0;
      hour_d  = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
    end
  end

  // Time registers; reset starts a new day.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      hour_q  <= 5'(START_HOUR);
    end else begin
      cycle_q <= cycle_d;
      hour_q  <= hour_d;
    end
  end

  assign hour = hour_q;

endmodule

// File: rtl/parking.sv
// Parking lot controller: hour-dependent pool capacities, entry/exit
// accounting per pool, vacancy reporting and illegal-request flags.
module parking
  import parking_pkg::*;
#(
  parameter int CYCLES_PER_HOUR = parking_pkg::CYCLES_PER_HOUR,
  parameter int TOTAL_SPACES    = parking_pkg::TOTAL_SPACES,
  parameter int START_HOUR      = parking_pkg::START_HOUR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_entered,
  input  logic       is_uni_car_entered,
  input  logic       car_exited,
  input  logic       is_uni_car_exited,
  output logic [8:0] uni_parked_car,
  output logic [8:0] parked_car,
  output logic [8:0] uni_vacated_space,
  output logic [8:0] vacated_space,
  output logic       uni_is_vacated_space,
  output logic       is_vacated_space,
  output logic       illegal_enter,
  output logic       illegal_exit
);

  logic [4:0] hour;
  count_t     uni_cap, gen_cap;
  count_t     uni_q, uni_d, gen_q, gen_d;
  logic       ill_enter_q, ill_enter_d, ill_exit_q, ill_exit_d;
  logic       uni_in_ok, gen_in_ok, uni_out_ok, gen_out_ok;

  parking_clock #(
    .CYCLES_PER_HOUR(CYCLES_PER_HOUR),
    .START_HOUR     (START_HOUR)
  ) u_clock (
    .clk  (clk),
    .reset(reset),
    .hour (hour)
  );

  // Pool capacities for the current hour; general gets the remainder.
  always_comb begin
    uni_cap = uni_capacity(hour);
    gen_cap = count_t'(TOTAL_SPACES - int'(uni_cap));
  end

  // Entry and exit both judged on pre-cycle counts, then both applied.
  always_comb begin
    uni_in_ok   = car_entered &&  is_uni_car_entered && (uni_q < uni_cap);
    gen_in_ok   = car_entered && !is_uni_car_entered && (gen_q < gen_cap);
    uni_out_ok  = car_exited  &&  is_uni_car_exited  && (uni_q != '0);
    gen_out_ok  = car_exited  && !is_uni_car_exited  && (gen_q != '0);
    ill_enter_d = car_entered && !(uni_in_ok || gen_in_ok);
    ill_exit_d  = car_exited  && !(uni_out_ok || gen_out_ok);
    uni_d       = uni_q + count_t'(uni_in_ok) - count_t'(uni_out_ok);
    gen_d       = gen_q + count_t'(gen_in_ok) - count_t'(gen_out_ok);
  end

  // Occupancy counts and illegal-request flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      uni_q       <= '0;
      gen_q       <= '0;
      ill_enter_q <= 1'b0;
      ill_exit_q  <= 1'b0;
    end else begin
      uni_q       <= uni_d;
      gen_q       <= gen_d;
      ill_enter_q <= ill_enter_d;
      ill_exit_q  <= ill_exit_d;
    end
  end

  // Vacancy saturates at zero when capacity drops below occupancy.
  always_comb begin
    uni_vacated_space = (uni_cap > uni_q) ? uni_cap - uni_q : '0;
    vacated_space     = (gen_cap > gen_q) ? gen_cap - gen_q : '0;
  end

  assign uni_parked_car       = uni_q;
  assign parked_car           = gen_q;
  assign uni_is_vacated_space = (uni_vacated_space != '0);
  assign is_vacated_space     = (vacated_space != '0);
  assign illegal_enter        = ill_enter_q;
  assign illegal_exit         = ill_exit_q;

endmodule

// File: tb/tb_parking.sv
// Randomised and directed bench for parking against a behavioural lot model.
module tb_parking;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_entered = 1'b0, is_uni_car_entered = 1'b0;
  logic       car_exited = 1'b0, is_uni_car_exited = 1'b0;
  logic [8:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
  logic       uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit;

  parking dut (
    .clk                 (clk),
    .reset               (reset),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .uni_parked_car      (uni_parked_car),
    .parked_car          (parked_car),
    .uni_vacated_space   (uni_vacated_space),
    .vacated_space       (vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .illegal_enter       (illegal_enter),
    .illegal_exit        (illegal_exit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: cars per pool, cycles elapsed since reset, flags.
  int  m_uni = 0, m_gen = 0, m_elapsed = 0;
  bit  m_ill_en = 0, m_ill_ex = 0;
  int  ucap_tbl [24];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_hour();
    return (8 + m_elapsed / 256) % 24;
  endfunction

  function automatic int sat(input int v);
    return (v > 0) ? v : 0;
  endfunction

  task automatic compare_all();
    int uc, gc;
    uc = ucap_tbl[m_hour()];
    gc = 700 - uc;
    check("uni_parked", int'(uni_parked_car), m_uni);
    check("gen_parked", int'(parked_car), m_gen);
    check("uni_vac", int'(uni_vacated_space), sat(uc - m_uni));
    check("gen_vac", int'(vacated_space), sat(gc - m_gen));
    check("uni_is_vac", int'(uni_is_vacated_space), int'(uc > m_uni));
    check("gen_is_vac", int'(is_vacated_space), int'(gc > m_gen));
    check("ill_enter", int'(illegal_enter), int'(m_ill_en));
    check("ill_exit", int'(illegal_exit), int'(m_ill_ex));
  endtask

  // One clock: drive inputs, advance model on the edge, compare after it.
  task automatic step(input bit rst, input bit ce, input bit ue,
                      input bit cx, input bit ux);
    int uc, gc;
    bit ui, gi, uo, go;
    reset = rst; car_entered = ce; is_uni_car_entered = ue;
    car_exited = cx; is_uni_car_exited = ux;
    @(posedge clk);
    if (rst) begin
      m_uni = 0; m_gen = 0; m_elapsed = 0; m_ill_en = 0; m_ill_ex = 0;
    end else begin
      uc = ucap_tbl[m_hour()];
      gc = 700 - uc;
      ui = ce &&  ue && (m_uni < uc);
      gi = ce && !ue && (m_gen < gc);
      uo = cx &&  ux && (m_uni > 0);
      go = cx && !ux && (m_gen > 0);
      m_ill_en = ce && !ui && !gi;
      m_ill_ex = cx && !uo && !go;
      m_uni = m_uni + int'(ui) - int'(uo);
      m_gen = m_gen + int'(gi) - int'(go);
      m_elapsed++;
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int h = 0; h < 24; h++) ucap_tbl[h] = 200;
    for (int h = 8; h <= 12; h++) ucap_tbl[h] = 500;
    ucap_tbl[13] = 450; ucap_tbl[14] = 400; ucap_tbl[15] = 350;

    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(1);
    check("rst_uni_vac", int'(uni_vacated_space), 500);
    check("rst_gen_vac", int'(vacated_space), 200);

    // Continuous uni entries from reset release, through hour 16.
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 256; i++) step(0, 1, 1, 0, 0);
    check("uni_after_256", int'(uni_parked_car), 256);
    for (int i = 257; i <= 500; i++) step(0, 1, 1, 0, 0);
    check("uni_after_500", int'(uni_parked_car), 500);
    check("uni_vac_full", int'(uni_vacated_space), 0);
    step(0, 1, 1, 0, 0);
    check("uni_rejected", int'(illegal_enter), 1);
    for (int i = 502; i <= 8 * 256 + 4; i++) step(0, 1, 1, 0, 0);
    check("h16_uni", int'(uni_parked_car), 500);
    check("h16_gen_vac", int'(vacated_space), 500);
    check("h16_gen", int'(parked_car), 0);

    // 201 general entries at hour 8.
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 200; i++) step(0, 1, 0, 0, 0);
    check("gen_200_no_flag", int'(illegal_enter), 0);
    step(0, 1, 0, 0, 0);
    check("gen_201_flag", int'(illegal_enter), 1);
    check("gen_full", int'(parked_car), 200);
    idle(1);

    // Empty-pool exits and simultaneous entry/exit.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    check("uni_empty_exit", int'(illegal_exit), 1);
    step(0, 0, 0, 1, 0);
    check("gen_empty_exit", int'(illegal_exit), 1);
    idle(1);
    check("exit_flag_clears", int'(illegal_exit), 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1);
    check("simul_uni", int'(uni_parked_car), 10);
    check("simul_no_ien", int'(illegal_enter), 0);
    check("simul_no_iex", int'(illegal_exit), 0);

    // Mid-afternoon reset with cars parked.
    for (int i = 0; i < 6 * 256; i++) step(0, 1, i[0], i % 7 == 0, i[1]);
    step(1, 1, 1, 1, 0);
    check("mid_rst_uni_vac", int'(uni_vacated_space), 500);
    check("mid_rst_gen_vac", int'(vacated_space), 200);

    // Randomised traffic across the day, with rare resets.
    for (int i = 0; i < 9000; i++) begin
      step($urandom_range(0, 2999) == 0,
           $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 35, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard cap on simulated time.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking.md
Name: parking

Overview:
- Synchronous controller for a 700-space lot, shared between university cars and general (non-university) cars.
- Tracks the time of day from an internal cycle counter; the day starts at 08:00 on reset.
- Derives each pool's capacity from the hour, and counts entries and exits per pool.
- Reports occupancy, vacancy and illegal entry/exit attempts. Sits between gate sensors and a display/gate-control unit.

Parameters:
- CYCLES_PER_HOUR, 256, clock cycles per simulated hour.
- TOTAL_SPACES, 700, total lot capacity.
- START_HOUR, 8, hour loaded at reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; starts a new day.
- car_entered  in  1  a car requests entry this cycle.
- is_uni_car_entered  in  1  entering car is a university car (valid with car_entered).
- car_exited  in  1  a car exits this cycle.
- is_uni_car_exited  in  1  exiting car is a university car (valid with car_exited).
- uni_parked_car  out  9  university cars currently parked.
- parked_car  out  9  general cars currently parked.
- uni_vacated_space  out  9  free university spaces.
- vacated_space  out  9  free general spaces.
- uni_is_vacated_space  out  1  uni_vacated_space != 0.
- is_vacated_space  out  1  vacated_space != 0.
- illegal_enter  out  1  last entry request was rejected.
- illegal_exit  out  1  last exit request was rejected.

Behaviour:
- Reset:
  - Hour = START_HOUR; cycle counter = 0; both parked counts = 0.
  - illegal_enter = illegal_exit = 0.
  - Vacancies therefore read 500 (uni) and 200 (general).
- Time keeping:
  - The cycle counter runs 0..CYCLES_PER_HOUR-1.
  - On terminal count it clears and the hour increments.
  - Hour wraps 23 -> 0.
- University capacity U by hour:
  - 8..12: 500.
  - 13: 450.
  - 14: 400.
  - 15: 350.
  - 16..23 and 0..7: 200.
- General capacity G = TOTAL_SPACES - U, giving 200 / 250 / 300 / 350 / 500.
- Vacancy (combinational from registered counts and current hour):
  - uni_vacated_space = U - uni_parked_car if positive, else 0.
  - vacated_space is the same using G and parked_car.
  - When capacity shrinks below occupancy, vacancy saturates at 0. Cars are never evicted.
- Entry (per cycle, when car_entered = 1):
  - Uni car: accepted when uni_parked_car < U, which increments the count. Otherwise it is rejected.
  - General car: accepted when parked_car < G, which increments the count. Otherwise it is rejected.
- Exit (per cycle, when car_exited = 1):
  - A matching-pool count above 0 decrements.
  - A count of 0 is rejected and the count is unchanged.
- Simultaneous entry and exit in one cycle: both are evaluated against pre-cycle counts and both are applied.
  - Same pool, both accepted: net count unchanged.
- illegal_enter / illegal_exit:
  - Registered; each is 1 in the cycle following a rejected request, otherwise 0.
  - A continuously rejected stream holds the flag high.
- Latency: counts update on the edge that samples the request, so new values are visible one cycle after the request.
- Counts never exceed 500, so 9 bits suffice. No wrap or underflow is possible.
- Reset mid-day: the next edge restores the full reset state regardless of other inputs.

Decomposition:
- Package parking_pkg holds:
  - constants TOTAL_SPACES, CYCLES_PER_HOUR, START_HOUR;
  - the capacity-table function hour -> U;
  - a 9-bit count typedef.
- One sub-module, parking_clock: the cycle/hour counter, which outputs the 5-bit hour.

Test Plan:
- Reset, then idle for 1 cycle -> all counts 0, uni_vacated_space = 500, vacated_space = 200, both is_* = 1, both illegal flags = 0.
- Uni car entry held high every cycle from reset release:
  - After 256 cycles, uni_parked_car = 256.
  - After 500 cycles, uni_parked_car = 500, uni_vacated_space = 0, illegal_enter = 1 thereafter.
- Continue to hour 13/14/15/16 -> uni_parked_car stays 500, uni_vacated_space = 0, vacated_space = 250/300/350/500, parked_car = 0.
- General entries: 201 requests at hour 8 -> parked_car = 200, illegal_enter = 1 after the 201st request only.
- Exit with empty pool -> illegal_exit = 1 for one cycle, counts unchanged. Simultaneous uni entry and uni exit with uni_parked_car = 10 -> stays 10, no flags.
- Reset asserted mid-afternoon with cars parked -> next cycle hour = 8, counts 0, vacancies 500/200.
